next_pc_btb_predictor: RTL and testbench

Fetch-stage next-PC generator with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It produces FETCH_WIDTH sequential instruction addresses per cycle from a registered fetch-group PC and truncates the group at the first predicted-taken slot, steering the next group to the BTB target. It sits at the head of the front end, takes redirects from execute and decode, and learns from execute-resolved branches.

---
 rtl/next_pc_btb_predictor_pkg.sv | 34 +++
 rtl/next_pc_btb_predictor_btb_table.sv | 71 +++++++
 rtl/next_pc_btb_predictor.sv | 87 ++++++++
 tb/tb_next_pc_btb_predictor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/next_pc_btb_predictor_pkg.sv
// Shared types and constants for the fetch next-PC predictor and its BTB.
// Table geometry (entries, address width) is fixed here and sizes the entry struct.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package next_pc_btb_predictor_pkg;

  localparam int PKG_ADDR_WIDTH  = `ADDR_WIDTH;
  localparam int PKG_BTB_ENTRIES = 16;
  localparam int IDX_BITS        = $clog2(PKG_BTB_ENTRIES);
  localparam int TAG_BITS        = PKG_ADDR_WIDTH - IDX_BITS - 2;

  localparam logic [1:0] CTR_WEAK_T = 2'd2;
  localparam logic [1:0] CTR_MAX    = 2'd3;

  typedef logic [PKG_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    addr_t               target;
    logic [1:0]          ctr;
  } btb_entry_t;

  function automatic logic [IDX_BITS-1:0] btb_idx(input addr_t a);
    return a[IDX_BITS+1:2];
  endfunction

  function automatic logic [TAG_BITS-1:0] btb_tag(input addr_t a);
    return a[PKG_ADDR_WIDTH-1:IDX_BITS+2];
  endfunction

endpackage

// File: rtl/next_pc_btb_predictor_btb_table.sv
// Direct-mapped BTB: FETCH_WIDTH combinational lookups, one training write port.
// Writes land at the next edge with no read bypass; reset/flush clear valid bits and drop the write.
module next_pc_btb_predictor_btb_table
  import next_pc_btb_predictor_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int BTB_ENTRIES = PKG_BTB_ENTRIES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  addr_t [FETCH_WIDTH-1:0]      rd_addr_i,
  output logic  [FETCH_WIDTH-1:0]      rd_taken_o,
  output addr_t [FETCH_WIDTH-1:0]      rd_target_o,
  input  logic                         wr_en_i,
  input  addr_t                        wr_pc_i,
  input  logic                         wr_taken_i,
  input  addr_t                        wr_target_i
);

  btb_entry_t entries_q [BTB_ENTRIES];

  for (genvar s = 0; s < FETCH_WIDTH; s++) begin : g_rd
    btb_entry_t rd_entry;
    assign rd_entry       = entries_q[btb_idx(rd_addr_i[s])];
    assign rd_taken_o[s]  = rd_entry.valid && (rd_entry.tag == btb_tag(rd_addr_i[s])) && rd_entry.ctr[1];
    assign rd_target_o[s] = rd_entry.target;
  end

  logic [IDX_BITS-1:0] wr_idx;
  btb_entry_t          wr_old;
  btb_entry_t          wr_entry_d;
  logic                wr_hit;
  logic                wr_we;

  assign wr_idx = btb_idx(wr_pc_i);
  assign wr_old = entries_q[wr_idx];
  assign wr_hit = wr_old.valid && (wr_old.tag == btb_tag(wr_pc_i));

  // Not-taken on a miss leaves the table alone; not-taken on a hit keeps the entry valid.
  always_comb begin
    wr_entry_d = wr_old;
    wr_we      = 1'b0;
    if (wr_en_i) begin
      if (wr_taken_i) begin
        wr_we = 1'b1;
        if (wr_hit) begin
          wr_entry_d.target = wr_target_i;
          if (wr_old.ctr != CTR_MAX) wr_entry_d.ctr = wr_old.ctr + 2'd1;
        end else begin
          wr_entry_d.valid  = 1'b1;
          wr_entry_d.tag    = btb_tag(wr_pc_i);
          wr_entry_d.target = wr_target_i;
          wr_entry_d.ctr    = CTR_WEAK_T;
        end
      end else if (wr_hit) begin
        wr_we = 1'b1;
        if (wr_old.ctr != 2'd0) wr_entry_d.ctr = wr_old.ctr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      for (int e = 0; e < BTB_ENTRIES; e++) entries_q[e].valid <= 1'b0;
    end else if (wr_we) begin
      entries_q[wr_idx] <= wr_entry_d;
    end
  end

endmodule

// File: rtl/next_pc_btb_predictor.sv
// Fetch next-PC generator: sequential slot addresses, group truncated at the first predicted-taken slot.
// Outputs are combinational from pc_q and the BTB; redirects override stall, reset overrides all.
module next_pc_btb_predictor
  import next_pc_btb_predictor_pkg::*;
#(
  parameter int                    FETCH_WIDTH = 2,
  parameter int                    BTB_ENTRIES = PKG_BTB_ENTRIES,
  parameter int                    ADDR_WIDTH  = PKG_ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   ext_stall,
  input  logic                                   ext_flush,
  input  logic                                   ex_redirect,
  input  logic [ADDR_WIDTH-1:0]                  ex_redirect_pc,
  input  logic                                   dec_redirect,
  input  logic [ADDR_WIDTH-1:0]                  dec_redirect_pc,
  input  logic                                   ex_update,
  input  logic [ADDR_WIDTH-1:0]                  ex_pc,
  input  logic                                   ex_taken,
  input  logic [ADDR_WIDTH-1:0]                  ex_target,
  output logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] guess,
  output logic [FETCH_WIDTH-1:0]                 guess_valid,
  output logic [FETCH_WIDTH-1:0]                 guesses_branch
);

  logic [ADDR_WIDTH-1:0]                  pc_q;
  logic [ADDR_WIDTH-1:0]                  pc_d;
  logic [ADDR_WIDTH-1:0]                  next_pc;
  logic [FETCH_WIDTH-1:0]                 slot_taken;
  logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] slot_target;
  logic                                   taken_any;
  logic [ADDR_WIDTH-1:0]                  taken_target;

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
    assign guess[i] = pc_q + ADDR_WIDTH'(4 * i);
  end

  next_pc_btb_predictor_btb_table #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (ext_flush),
    .rd_addr_i   (guess),
    .rd_taken_o  (slot_taken),
    .rd_target_o (slot_target),
    .wr_en_i     (ex_update),
    .wr_pc_i     (ex_pc),
    .wr_taken_i  (ex_taken),
    .wr_target_i (ex_target)
  );

  // Lowest taken slot wins; every slot after it falls off the predicted path.
  always_comb begin
    guess_valid    = '1;
    guesses_branch = '0;
    taken_any      = 1'b0;
    taken_target   = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (taken_any) begin
        guess_valid[i] = 1'b0;
      end else if (slot_taken[i]) begin
        taken_any         = 1'b1;
        guesses_branch[i] = 1'b1;
        taken_target      = slot_target[i];
      end
    end
  end

  assign next_pc = taken_any ? taken_target : pc_q + ADDR_WIDTH'(4 * FETCH_WIDTH);

  always_comb begin
    pc_d = next_pc;
    if (ex_redirect)       pc_d = ex_redirect_pc;
    else if (dec_redirect) pc_d = dec_redirect_pc;
    else if (ext_stall)    pc_d = pc_q;
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

endmodule

// File: tb/tb_next_pc_btb_predictor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural BTB model.
module tb_next_pc_btb_predictor;

  localparam int          FW  = 2;
  localparam int          AW  = 32;
  localparam int          NE  = 16;
  localparam logic [31:0] RPC = 32'h0;

  logic                  clk;
  logic                  reset;
  logic                  ext_stall, ext_flush;
  logic                  ex_redirect, dec_redirect;
  logic [AW-1:0]         ex_redirect_pc, dec_redirect_pc;
  logic                  ex_update, ex_taken;
  logic [AW-1:0]         ex_pc, ex_target;
  logic [FW-1:0][AW-1:0] guess;
  logic [FW-1:0]         guess_valid, guesses_branch;

  int checks = 0;
  int errors = 0;

  next_pc_btb_predictor #(
    .FETCH_WIDTH (FW),
    .BTB_ENTRIES (NE),
    .ADDR_WIDTH  (AW),
    .RESET_PC    (RPC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .ext_stall       (ext_stall),
    .ext_flush       (ext_flush),
    .ex_redirect     (ex_redirect),
    .ex_redirect_pc  (ex_redirect_pc),
    .dec_redirect    (dec_redirect),
    .dec_redirect_pc (dec_redirect_pc),
    .ex_update       (ex_update),
    .ex_pc           (ex_pc),
    .ex_taken        (ex_taken),
    .ex_target       (ex_target),
    .guess           (guess),
    .guess_valid     (guess_valid),
    .guesses_branch  (guesses_branch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (!reset) begin
      assert (!ex_redirect || ex_redirect_pc[1:0] == 2'b00) else $error("unaligned ex_redirect_pc %h", ex_redirect_pc);
      assert (!dec_redirect || dec_redirect_pc[1:0] == 2'b00) else $error("unaligned dec_redirect_pc %h", dec_redirect_pc);
    end
  end

  // Behavioural model: one slot per index remembering the whole branch PC it learned.
  logic [AW-1:0] m_pc;
  bit            m_vld [NE];
  logic [AW-1:0] m_bpc [NE];
  logic [AW-1:0] m_tgt [NE];
  int            m_ctr [NE];

  function automatic int slot_of(input logic [AW-1:0] a);
    return int'((a >> 2) % NE);
  endfunction

  task automatic m_expect(output logic [FW-1:0][AW-1:0] eg, output logic [FW-1:0] ev,
                          output logic [FW-1:0] eb, output logic [AW-1:0] enext);
    bit found = 0;
    int s;
    logic [AW-1:0] a;
    enext = m_pc + 32'(4 * FW);
    for (int i = 0; i < FW; i++) begin
      a = m_pc + 32'(4 * i);
      eg[i] = a;
      eb[i] = 1'b0;
      ev[i] = !found;
      s = slot_of(a);
      if (!found && m_vld[s] && (m_bpc[s] >> 2) == (a >> 2) && m_ctr[s] >= 2) begin
        found = 1;
        eb[i] = 1'b1;
        enext = m_tgt[s];
      end
    end
  endtask

  task automatic m_clear();
    for (int e = 0; e < NE; e++) m_vld[e] = 0;
  endtask

  task automatic tick();
    logic [FW-1:0][AW-1:0] eg;
    logic [FW-1:0] ev, eb;
    logic [AW-1:0] nxt, npc;
    int s;
    bit hit;
    m_expect(eg, ev, eb, nxt);
    if (reset) begin
      npc = RPC;
      m_clear();
    end else begin
      if (ex_redirect)       npc = ex_redirect_pc;
      else if (dec_redirect) npc = dec_redirect_pc;
      else if (ext_stall)    npc = m_pc;
      else                   npc = nxt;
      if (ext_flush) m_clear();
      else if (ex_update) begin
        s = slot_of(ex_pc);
        hit = m_vld[s] && (m_bpc[s] >> 2) == (ex_pc >> 2);
        if (ex_taken) begin
          if (hit) begin
            m_tgt[s] = ex_target;
            m_ctr[s] = (m_ctr[s] < 3) ? m_ctr[s] + 1 : 3;
          end else begin
            m_vld[s] = 1; m_bpc[s] = ex_pc; m_tgt[s] = ex_target; m_ctr[s] = 2;
          end
        end else if (hit) begin
          m_ctr[s] = (m_ctr[s] > 0) ? m_ctr[s] - 1 : 0;
        end
      end
    end
    @(posedge clk);
    #1;
    m_pc = npc;
  endtask

  task automatic idle_inputs();
    ext_flush = 0; ex_redirect = 0; dec_redirect = 0; ex_update = 0; ex_taken = 0;
    ex_redirect_pc = '0; dec_redirect_pc = '0; ex_pc = '0; ex_target = '0;
  endtask

  task automatic redirect_to(input logic [AW-1:0] pc);
    ex_redirect = 1; ex_redirect_pc = pc;
    tick();
    ex_redirect = 0;
  endtask

  task automatic train(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tgt);
    ex_update = 1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    tick();
    ex_update = 0;
  endtask

  task automatic test_reset();
    reset = 1; ext_stall = 0; idle_inputs();
    m_pc = 32'hDEAD_BEE0;
    tick(); tick();
    reset = 0;
    checks++; if (guess[0] !== 32'h0 || guess[1] !== 32'h4) begin errors++;
      $display("FAIL reset_guess got %h/%h exp 0/4", guess[0], guess[1]); end
    checks++; if (guess_valid !== 2'b11) begin errors++;
      $display("FAIL reset_valid got %b exp 11", guess_valid); end
    checks++; if (guesses_branch !== 2'b00) begin errors++;
      $display("FAIL reset_branch got %b exp 00", guesses_branch); end
    tick(); tick(); tick();
    checks++; if (guess[0] !== 32'h18) begin errors++;
      $display("FAIL seq_advance got %h exp 18", guess[0]); end
    ext_stall = 1;
    tick(); tick();
    checks++; if (guess[0] !== 32'h18) begin errors++;
      $display("FAIL stall_hold got %h exp 18", guess[0]); end
  endtask

  task automatic test_slot0_taken();
    train(32'h20, 1'b1, 32'h100);
    ext_stall = 0;
    tick();
    checks++; if (guess[0] !== 32'h20 || guess_valid !== 2'b01 || guesses_branch !== 2'b01) begin errors++;
      $display("FAIL slot0_hit got pc %h v %b b %b exp 20/01/01", guess[0], guess_valid, guesses_branch); end
    tick();
    checks++; if (guess[0] !== 32'h100) begin errors++;
      $display("FAIL slot0_target got %h exp 100", guess[0]); end
  endtask

  task automatic test_slot1_taken();
    ex_update = 1; ex_pc = 32'h44; ex_taken = 1; ex_target = 32'h80;
    redirect_to(32'h40);
    ex_update = 0;
    checks++; if (guess[0] !== 32'h40 || guess_valid !== 2'b11 || guesses_branch !== 2'b10) begin errors++;
      $display("FAIL slot1_hit got pc %h v %b b %b exp 40/11/10", guess[0], guess_valid, guesses_branch); end
    tick();
    checks++; if (guess[0] !== 32'h80) begin errors++;
      $display("FAIL slot1_target got %h exp 80", guess[0]); end
  endtask

  task automatic test_redirect_priority();
    ext_stall = 1;
    dec_redirect = 1; dec_redirect_pc = 32'h300;
    redirect_to(32'h200);
    dec_redirect = 0; ext_stall = 0;
    checks++; if (guess[0] !== 32'h200) begin errors++;
      $display("FAIL ex_over_dec got %h exp 200", guess[0]); end
    dec_redirect = 1; dec_redirect_pc = 32'h300;
    tick();
    dec_redirect = 0;
    checks++; if (guess[0] !== 32'h300) begin errors++;
      $display("FAIL dec_redirect got %h exp 300", guess[0]); end
  endtask

  task automatic test_counters();
    train(32'h20, 1'b0, 32'h0);
    train(32'h20, 1'b0, 32'h0);
    redirect_to(32'h20);
    checks++; if (guess_valid !== 2'b11 || guesses_branch !== 2'b00) begin errors++;
      $display("FAIL ctr_weakened got v %b b %b exp 11/00", guess_valid, guesses_branch); end
    tick();
    checks++; if (guess[0] !== 32'h28) begin errors++;
      $display("FAIL ctr_fallthrough got %h exp 28", guess[0]); end
    for (int n = 0; n < 4; n++) train(32'h20, 1'b1, 32'h100);
    train(32'h20, 1'b0, 32'h0);
    redirect_to(32'h20);
    checks++; if (guesses_branch !== 2'b01) begin errors++;
      $display("FAIL ctr_saturated got b %b exp 01", guesses_branch); end
    tick();
    checks++; if (guess[0] !== 32'h100) begin errors++;
      $display("FAIL ctr_sat_target got %h exp 100", guess[0]); end
    train(32'h20, 1'b0, 32'h0);
    redirect_to(32'h20);
    checks++; if (guesses_branch !== 2'b00) begin errors++;
      $display("FAIL ctr_drop_weak got b %b exp 00", guesses_branch); end
    train(32'h20, 1'b1, 32'h100);
    train(32'h20, 1'b1, 32'h100);
  endtask

  task automatic test_flush();
    ext_flush = 1;
    train(32'h60, 1'b1, 32'h500);
    ext_flush = 0;
    redirect_to(32'h60);
    checks++; if (guess_valid !== 2'b11 || guesses_branch !== 2'b00) begin errors++;
      $display("FAIL flush_drop_alloc got v %b b %b exp 11/00", guess_valid, guesses_branch); end
    tick();
    checks++; if (guess[0] !== 32'h68) begin errors++;
      $display("FAIL flush_fallthrough got %h exp 68", guess[0]); end
    redirect_to(32'h20);
    checks++; if (guesses_branch !== 2'b00) begin errors++;
      $display("FAIL flush_clears_old got b %b exp 00", guesses_branch); end
  endtask

  task automatic test_random();
    logic [FW-1:0][AW-1:0] eg;
    logic [FW-1:0] ev, eb;
    logic [AW-1:0] en;
    for (int c = 0; c < 600; c++) begin
      m_expect(eg, ev, eb, en);
      checks++; if (guess !== eg) begin errors++;
        $display("FAIL rand_guess cyc %0d got %h exp %h", c, guess, eg); end
      checks++; if (guess_valid !== ev) begin errors++;
        $display("FAIL rand_valid cyc %0d got %b exp %b", c, guess_valid, ev); end
      checks++; if (guesses_branch !== eb) begin errors++;
        $display("FAIL rand_branch cyc %0d got %b exp %b", c, guesses_branch, eb); end
      reset           = ($urandom_range(0, 63) == 0);
      ext_flush       = ($urandom_range(0, 31) == 0);
      ext_stall       = ($urandom_range(0, 3) == 0);
      ex_redirect     = ($urandom_range(0, 7) == 0);
      dec_redirect    = ($urandom_range(0, 7) == 0);
      ex_redirect_pc  = 32'($urandom_range(0, 255)) << 2;
      dec_redirect_pc = 32'($urandom_range(0, 255)) << 2;
      ex_update       = ($urandom_range(0, 1) == 0);
      ex_pc           = 32'($urandom_range(0, 255)) << 2;
      ex_taken        = ($urandom_range(0, 2) != 0);
      ex_target       = 32'($urandom_range(0, 255)) << 2;
      tick();
    end
    reset = 0; ext_stall = 0; idle_inputs();
  endtask

  initial begin
    test_reset();
    test_slot0_taken();
    test_slot1_taken();
    test_redirect_priority();
    test_counters();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
